// File: rtl/test_dut.sv
// Sampled-input monitor: captures {Q3,Q2,Q1} when C is high and
// reports per-bit edges, run length and vector flags, all registered.
module test_dut #(
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Q3,
  input  logic             Q2,
  input  logic             Q1,
  input  logic             C,
  output logic [2:0]       Q_out,
  output logic [2:0]       Rise,
  output logic [2:0]       Fall,
  output logic [CNT_W-1:0] Run_cnt,
  output logic             Valid,
  output logic             All_one,
  output logic             Parity
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [2:0]       w_s;
  logic [2:0]       r_q;
  logic [2:0]       r_rise;
  logic [2:0]       r_fall;
  logic [CNT_W-1:0] r_cnt;
  logic             r_valid;
  logic             w_cnt_max;

  assign w_s       = {Q3, Q2, Q1};
  assign w_cnt_max = (r_cnt == CNT_MAX);

  // Edges are taken against the last capture, even across C=0 gaps.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_q     <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else if (C) begin
      r_q     <= w_s;
      r_rise  <= w_s & ~r_q;
      r_fall  <= ~w_s & r_q;
      r_valid <= 1'b1;
      if (!w_cnt_max)
        r_cnt <= r_cnt + 1'b1;
    end else begin
      r_rise  <= '0;
      r_fall  <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end
  end

  assign Q_out   = r_q;
  assign Rise    = r_rise;
  assign Fall    = r_fall;
  assign Run_cnt = r_cnt;
  assign Valid   = r_valid;
  assign All_one = &r_q;
  assign Parity  = ^r_q;

endmodule

// File: tb/tb_test_dut.sv
// Bench for test_dut: vector table, directed corner sequences and
// random traffic against a behavioural model.
module tb_test_dut;

  localparam int CNT_W = 8;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             Clk = 1'b0;
  logic             Rst_n;
  logic             Q3, Q2, Q1, C;
  logic [2:0]       Q_out, Rise, Fall;
  logic [CNT_W-1:0] Run_cnt;
  logic             Valid, All_one, Parity;

  int n_cmp = 0;
  int n_bad = 0;

  // behavioural model state
  int m_q, m_rise, m_fall, m_cnt, m_valid;

  typedef struct {
    logic       c;
    logic [2:0] s;
    logic [2:0] q;
    logic [2:0] r;
    logic [2:0] f;
    int         cnt;
    logic       v;
    logic       a;
    logic       p;
  } vec_t;

  vec_t tbl [6];

  test_dut #(.CNT_W(CNT_W)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .Q3(Q3), .Q2(Q2), .Q1(Q1), .C(C),
    .Q_out(Q_out), .Rise(Rise), .Fall(Fall),
    .Run_cnt(Run_cnt), .Valid(Valid),
    .All_one(All_one), .Parity(Parity)
  );

  always #5 Clk = ~Clk;

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic mreset();
    m_q = 0; m_rise = 0; m_fall = 0;
    m_cnt = 0; m_valid = 0;
  endtask

  // Model of one rising edge, written from the behavioural rules.
  task automatic mclk(logic c, logic [2:0] s);
    int sv;
    sv = int'(s);
    if (!Rst_n) begin
      mreset();
    end else if (c) begin
      m_rise  = sv & ~m_q & 7;
      m_fall  = ~sv & m_q & 7;
      m_q     = sv;
      m_cnt   = (m_cnt < MAXC) ? m_cnt + 1 : MAXC;
      m_valid = 1;
    end else begin
      m_rise  = 0;
      m_fall  = 0;
      m_cnt   = 0;
      m_valid = 0;
    end
  endtask

  task automatic check_model(string tag);
    chk({tag, ".q"}, int'(Q_out), m_q);
    chk({tag, ".rise"}, int'(Rise), m_rise);
    chk({tag, ".fall"}, int'(Fall), m_fall);
    chk({tag, ".cnt"}, int'(Run_cnt), m_cnt);
    chk({tag, ".valid"}, int'(Valid), m_valid);
    chk({tag, ".all"}, int'(All_one), (m_q == 7) ? 1 : 0);
    chk({tag, ".par"}, int'(Parity), $countones(m_q) % 2);
  endtask

  task automatic check_zero(string tag);
    chk({tag, ".q"}, int'(Q_out), 0);
    chk({tag, ".rise"}, int'(Rise), 0);
    chk({tag, ".fall"}, int'(Fall), 0);
    chk({tag, ".cnt"}, int'(Run_cnt), 0);
    chk({tag, ".valid"}, int'(Valid), 0);
    chk({tag, ".all"}, int'(All_one), 0);
    chk({tag, ".par"}, int'(Parity), 0);
  endtask

  // Drive mid-period, take one edge, settle past it.
  task automatic step(logic c, logic [2:0] s);
    @(negedge Clk);
    C = c;
    {Q3, Q2, Q1} = s;
    @(posedge Clk);
    mclk(c, s);
    #1;
  endtask

  initial begin
    tbl[0] = '{1'b1, 3'b001, 3'b001, 3'b001, 3'b000, 1, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 3'b011, 3'b011, 3'b010, 3'b000, 2, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 3'b111, 3'b111, 3'b100, 3'b000, 3, 1'b1, 1'b1, 1'b1};
    tbl[3] = '{1'b1, 3'b110, 3'b110, 3'b000, 3'b001, 4, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 3'b000, 3'b110, 3'b000, 3'b000, 0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 3'b001, 3'b001, 3'b001, 3'b110, 1, 1'b1, 1'b0, 1'b1};

    mreset();
    Rst_n = 1'b0;
    C = 1'b1;
    {Q3, Q2, Q1} = 3'b111;

    // reset held with live activity on the inputs
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk);
      #1;
      check_zero("rst_hold");
    end
    Rst_n = 1'b1;
    step(1'b1, 3'b111);
    chk("rel.q", int'(Q_out), 7);
    chk("rel.rise", int'(Rise), 7);
    chk("rel.cnt", int'(Run_cnt), 1);
    chk("rel.all", int'(All_one), 1);
    chk("rel.par", int'(Parity), 1);

    // ramp and gap from a clean reset
    @(negedge Clk);
    Rst_n = 1'b0;
    C = 1'b0;
    mreset();
    #1;
    check_zero("rst2");
    Rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].c, tbl[i].s);
      chk($sformatf("tbl%0d.q", i), int'(Q_out), int'(tbl[i].q));
      chk($sformatf("tbl%0d.rise", i), int'(Rise), int'(tbl[i].r));
      chk($sformatf("tbl%0d.fall", i), int'(Fall), int'(tbl[i].f));
      chk($sformatf("tbl%0d.cnt", i), int'(Run_cnt), tbl[i].cnt);
      chk($sformatf("tbl%0d.v", i), int'(Valid), int'(tbl[i].v));
      chk($sformatf("tbl%0d.all", i), int'(All_one), int'(tbl[i].a));
      chk($sformatf("tbl%0d.par", i), int'(Parity), int'(tbl[i].p));
    end

    // saturation: 260 qualified cycles after a gap
    step(1'b0, 3'b000);
    for (int i = 0; i < 260; i++) begin
      step(1'b1, 3'($urandom_range(0, 7)));
      check_model("sat");
    end
    chk("sat.cnt", int'(Run_cnt), 255);
    step(1'b0, 3'b101);
    chk("sat.clr", int'(Run_cnt), 0);

    // asynchronous reset between edges during a run
    step(1'b1, 3'b111);
    step(1'b1, 3'b101);
    #2;
    Rst_n = 1'b0;
    mreset();
    #1;
    check_zero("async");
    Rst_n = 1'b1;
    step(1'b1, 3'b010);
    chk("arel.rise", int'(Rise), 2);
    chk("arel.cnt", int'(Run_cnt), 1);
    check_model("arel");

    // hidden change while unqualified
    step(1'b1, 3'b000);
    @(negedge Clk);
    C = 1'b0;
    {Q3, Q2, Q1} = 3'b000;
    @(posedge Clk);
    mclk(1'b0, 3'b000);
    #2;
    {Q3, Q2, Q1} = 3'b101;
    #1;
    check_model("hid_mid");
    #2;
    {Q3, Q2, Q1} = 3'b000;
    @(posedge Clk);
    mclk(1'b0, 3'b000);
    #1;
    check_model("hid_edge");
    step(1'b1, 3'b000);
    chk("hid.rise", int'(Rise), 0);
    chk("hid.fall", int'(Fall), 0);
    chk("hid.cnt", int'(Run_cnt), 1);

    // random traffic with occasional async resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        #2;
        Rst_n = 1'b0;
        mreset();
        #1;
        check_model("rnd_rst");
        Rst_n = 1'b1;
      end
      step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)));
      check_model("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/test_dut.md
# test_dut

Sampled-input monitor for the `test` block. It captures a 3-bit status vector {Q3,Q2,Q1} on every clock where the qualifier C is high, and derives per-bit edge pulses, a run-length counter of consecutive qualified cycles, and simple vector flags. It is a small synchronous observer placed between raw status lines and downstream control/debug logic. All outputs are registered.

## Interface
Parameters:
- CNT_W, default 8: width of the run-length counter; the counter saturates at 2^CNT_W−1.

Ports (`test` module):
- Clk  input  1  system clock; all state updates on the rising edge.
- Rst_n  input  1  reset, asynchronous and active-low.
- Q3  input  1  status bit 2 (MSB) of the sampled vector.
- Q2  input  1  status bit 1.
- Q1  input  1  status bit 0 (LSB).
- C  input  1  sample qualifier; a vector is captured only when C=1.
- Q_out  output  3  last captured vector {Q3,Q2,Q1}.
- Rise  output  3  per-bit 0→1 pulse for the current capture.
- Fall  output  3  per-bit 1→0 pulse for the current capture.
- Run_cnt  output  CNT_W  count of consecutive qualified cycles.
- Valid  output  1  registered copy of C.
- All_one  output  1  high when Q_out==3'b111.
- Parity  output  1  XOR reduction of Q_out.

## Operation
- Define S = {Q3,Q2,Q1}, sampled at the rising edge of Clk.
- C=1 edge:
  - Q_out ← S.
  - Rise ← S & ~Q_out_old.
  - Fall ← ~S & Q_out_old.
  - Run_cnt ← Run_cnt+1, saturating at the maximum value (no wrap).
  - Valid ← 1.
- C=0 edge:
  - Q_out holds its value.
  - Rise ← 0, Fall ← 0.
  - Run_cnt ← 0.
  - Valid ← 0.
- All_one and Parity are combinational functions of the Q_out register only. They never depend on the live inputs.
- Edges are always computed against the last captured vector, including across C=0 gaps. A bit that changes while C=0 is therefore reported on the next C=1 capture.
- Asynchronous reset: Rst_n=0 immediately forces Q_out=0, Rise=0, Fall=0, Run_cnt=0, Valid=0. As a result, All_one=0 and Parity=0.
- Reset applied mid-run discards all history. The first capture after release compares against 000.

## Timing
- Latency: exactly 1 clock from an input sampled at an edge to every output. There is no combinational input→output path.
- Rise and Fall are single-cycle pulses. They are re-evaluated at every edge and are not sticky.
- Reset release is taken at the first rising edge where Rst_n=1.
- Saturation: with Run_cnt at max and C=1, Run_cnt stays at max while Q_out, Rise, Fall and Valid update normally.
- Inputs must be stable around the rising edge. Changes between edges have no effect.

## Test plan
- Reset: hold Rst_n=0 for several cycles with Q=111 and C=1 -> all outputs are 0. Release, then at the next edge Q_out=111, Rise=111, Run_cnt=1, All_one=1, Parity=1.
- Ramp: drive C=1 with S=001, 011, 111, 110 on successive cycles (inputs changing mid-period):
  - Q_out=001, 011, 111, 110.
  - Rise=001, 010, 100, 000.
  - Fall=000, 000, 000, 001.
  - Run_cnt=1, 2, 3, 4.
  - Parity=1, 0, 1, 0.
  - All_one=1 only on the third cycle.
- Gap: after the ramp, drive C=0 with S=000 for one cycle -> Q_out holds 110, Rise=Fall=000, Run_cnt=0, Valid=0. Next cycle C=1 with S=001 -> Q_out=001, Rise=001, Fall=110, Run_cnt=1, Valid=1.
- Saturation: hold C=1 for 260 cycles with CNT_W=8 -> Run_cnt stops at 255 and does not wrap. C=0 for one cycle -> Run_cnt=0.
- Async reset mid-run: assert Rst_n=0 between clock edges during a C=1 run -> outputs clear before the next edge. After release with S=010 and C=1 -> Rise=010, Run_cnt=1.
- Hidden change: with C=0, toggle S 000→101→000 between edges -> no output changes. Then C=1 with S=000 after Q_out=000 -> Rise=Fall=000, Run_cnt=1.
